// File: rtl/io_led_pkg.sv
// Shared types and constants for the io_led_bank LED driver.
package io_led_pkg;

    typedef enum logic [1:0] {
        FOLLOW = 2'd0,
        DIM    = 2'd1,
        BLINK  = 2'd2,
        OFF    = 2'd3
    } led_mode_t;

    localparam led_mode_t MODE_RST      = FOLLOW;
    localparam logic      LEVEL_RST_BIT = 1'b1;

    function automatic int cw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_led_sync.sv
// Two-flop synchroniser for asynchronous active-low requests; idles high.
module io_led_sync #(
    parameter int W = 1
) (
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_s1 <= '1;
            r_s2 <= '1;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/io_led_bank.sv
// Multi-channel active-low LED driver with per-channel modes and a
// round-robin valid/ready channel reporting lit-state changes.
module io_led_bank
    import io_led_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_BITS = 5,
    localparam int CW        = cw_of(CHANNELS)
) (
    input  logic                CLK,
    input  logic                _RESET,
    input  logic [CHANNELS-1:0] _I,
    input  logic                CFG_WE,
    input  logic [CW-1:0]       CFG_CHAN,
    input  logic [1:0]          CFG_MODE,
    input  logic [PWM_BITS-1:0] CFG_LEVEL,
    output logic [CHANNELS-1:0] _LED,
    output logic [CHANNELS-1:0] LIT,
    output logic                EVT_VALID,
    output logic [CW-1:0]       EVT_CHAN,
    output logic                EVT_ON,
    input  logic                EVT_READY
);

    logic [CHANNELS-1:0]   w_sync;
    logic [PWM_BITS-1:0]   r_pwm;
    logic [BLINK_BITS-1:0] r_blink;
    led_mode_t             r_mode  [CHANNELS];
    logic [PWM_BITS-1:0]   r_level [CHANNELS];
    logic                  w_cfg_hit;
    logic [CHANNELS-1:0]   w_lit;
    logic [CHANNELS-1:0]   w_drive;
    logic [CHANNELS-1:0]   r_lit;
    logic [CHANNELS-1:0]   r_led_n;
    logic [CHANNELS-1:0]   r_reported;
    logic [CHANNELS-1:0]   w_pending;
    logic [CW-1:0]         r_last;
    logic [CW-1:0]         r_chan;
    logic [CW-1:0]         w_pick;
    logic                  w_found;
    int                    w_idx;
    logic                  r_valid;
    logic                  r_on;

    io_led_sync #(.W(CHANNELS)) u_sync (
        .CLK    (CLK),
        ._RESET (_RESET),
        .i_d    (_I),
        .o_q    (w_sync)
    );

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_pwm   <= '0;
            r_blink <= '0;
        end else begin
            r_pwm   <= r_pwm + 1'b1;
            r_blink <= r_blink + 1'b1;
        end
    end

    assign w_cfg_hit = CFG_WE && (int'(CFG_CHAN) < CHANNELS);

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            for (int n = 0; n < CHANNELS; n++) begin
                r_mode[n]  <= MODE_RST;
                r_level[n] <= {PWM_BITS{LEVEL_RST_BIT}};
            end
        end else if (w_cfg_hit) begin
            r_mode[CFG_CHAN]  <= led_mode_t'(CFG_MODE);
            r_level[CFG_CHAN] <= CFG_LEVEL;
        end
    end

    always_comb begin
        w_lit   = '0;
        w_drive = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            unique case (r_mode[n])
                FOLLOW: w_lit[n] = ~w_sync[n];
                DIM:    w_lit[n] = ~w_sync[n];
                BLINK:  w_lit[n] = ~w_sync[n] & r_blink[BLINK_BITS-1];
                OFF:    w_lit[n] = 1'b0;
            endcase
            // PWM gating only dims the pin, never the logical lit state
            w_drive[n] = w_lit[n]
                       & ((r_mode[n] != DIM) | (r_pwm < r_level[n]));
        end
    end

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_lit   <= '0;
            r_led_n <= '1;
        end else begin
            r_lit   <= w_lit;
            r_led_n <= ~w_drive;
        end
    end

    assign w_pending = r_lit ^ r_reported;

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = 0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_idx = (int'(r_last) + 1 + i) % CHANNELS;
            if (!w_found && w_pending[w_idx]) begin
                w_found = 1'b1;
                w_pick  = CW'(w_idx);
            end
        end
    end

    // r_last starts at the top channel so the first search begins at 0
    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            r_valid    <= 1'b0;
            r_chan     <= '0;
            r_on       <= 1'b0;
            r_reported <= '0;
            r_last     <= CW'(CHANNELS - 1);
        end else if (r_valid) begin
            if (EVT_READY) begin
                r_valid            <= 1'b0;
                r_reported[r_chan] <= r_on;
                r_last             <= r_chan;
            end
        end else if (w_found) begin
            r_valid <= 1'b1;
            r_chan  <= w_pick;
            r_on    <= r_lit[w_pick];
        end
    end

    assign _LED      = r_led_n;
    assign LIT       = r_lit;
    assign EVT_VALID = r_valid;
    assign EVT_CHAN  = r_chan;
    assign EVT_ON    = r_on;

endmodule
